// File: rtl/serial_frame_deserializer_if.sv
// Serial-side and parallel-side signals of the frame deserializer.
// The slave modport is the deserializer; the master modport is its environment.
interface serial_frame_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_in;
    logic                  bit_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  data_ready;
    logic                  sync_locked;
    logic                  overflow;

    modport slave (
        input  serial_in, bit_en, data_ready,
        output data_out, data_valid, sync_locked, overflow
    );

    modport master (
        output serial_in, bit_en, data_ready,
        input  data_out, data_valid, sync_locked, overflow
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Hunts a serial stream for a sync word, captures the following DATA_WIDTH bits
// and presents them through a one-deep valid/ready output buffer.
module serial_frame_deserializer #(
    parameter int                    SYNC_WIDTH   = 7,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 7'b1111001,
    parameter int                    DATA_WIDTH   = 8,
    parameter bit                    MSB_FIRST    = 1'b1
) (
    input logic                      clk,
    input logic                      reset,
    serial_frame_deserializer_if.slave bus
);
    localparam int FW = $clog2(SYNC_WIDTH + 1);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {HUNT, CAPTURE} state_t;

    state_t                r_state, w_state_nx;
    logic [SYNC_WIDTH-1:0] r_hist, w_hist_nx, w_hist_sh;
    logic [FW-1:0]         r_fill, w_fill_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [DATA_WIDTH-1:0] r_pay, w_pay_nx, w_pay_sh;
    logic [DATA_WIDTH-1:0] r_data_out, w_data_out_nx;
    logic                  r_data_valid, w_data_valid_nx;
    logic                  r_overflow, w_overflow_nx;
    logic                  w_done, w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= HUNT;
            r_hist       <= '0;
            r_fill       <= '0;
            r_cnt        <= '0;
            r_pay        <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_hist       <= w_hist_nx;
            r_fill       <= w_fill_nx;
            r_cnt        <= w_cnt_nx;
            r_pay        <= w_pay_nx;
            r_data_out   <= w_data_out_nx;
            r_data_valid <= w_data_valid_nx;
            r_overflow   <= w_overflow_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_hist_nx  = r_hist;
        w_fill_nx  = r_fill;
        w_cnt_nx   = r_cnt;
        w_pay_nx   = r_pay;
        w_done     = 1'b0;
        w_hist_sh  = {r_hist[SYNC_WIDTH-2:0], bus.serial_in};
        w_pay_sh   = MSB_FIRST ? {r_pay[DATA_WIDTH-2:0], bus.serial_in}
                               : {bus.serial_in, r_pay[DATA_WIDTH-1:1]};

        if (bus.bit_en) begin
            unique case (r_state)
                HUNT: begin
                    w_hist_nx = w_hist_sh;
                    if (r_fill != FW'(SYNC_WIDTH))
                        w_fill_nx = r_fill + FW'(1);
                    // Fill count guarantees every matched bit arrived since entering HUNT
                    if (r_fill >= FW'(SYNC_WIDTH - 1) && w_hist_sh == SYNC_PATTERN) begin
                        w_state_nx = CAPTURE;
                        w_cnt_nx   = '0;
                        w_pay_nx   = '0;
                    end
                end
                CAPTURE: begin
                    w_pay_nx = w_pay_sh;
                    w_cnt_nx = r_cnt + CW'(1);
                    if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                        w_done     = 1'b1;
                        w_state_nx = HUNT;
                        w_hist_nx  = '0;
                        w_fill_nx  = '0;
                        w_cnt_nx   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_pop           = r_data_valid && bus.data_ready;
        w_data_out_nx   = r_data_out;
        w_data_valid_nx = w_pop ? 1'b0 : r_data_valid;
        w_overflow_nx   = 1'b0;
        // A completing word may load into the slot being popped this same edge
        if (w_done) begin
            if (!r_data_valid || bus.data_ready) begin
                w_data_out_nx   = w_pay_sh;
                w_data_valid_nx = 1'b1;
            end else begin
                w_overflow_nx = 1'b1;
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_valid  = r_data_valid;
    assign bus.sync_locked = (r_state == CAPTURE);
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Scoreboard bench for serial_frame_deserializer: MSB-first and LSB-first instances
// share one stimulus stream and are checked against a queue-based reference model.
module tb_serial_frame_deserializer;
    localparam int             DW  = 8;
    localparam int             SW  = 7;
    localparam logic [SW-1:0]  PAT = 7'b1111001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_frame_deserializer_if #(.DATA_WIDTH(DW)) bus_m ();
    serial_frame_deserializer_if #(.DATA_WIDTH(DW)) bus_l ();

    assign bus_l.serial_in  = bus_m.serial_in;
    assign bus_l.bit_en     = bus_m.bit_en;
    assign bus_l.data_ready = bus_m.data_ready;

    serial_frame_deserializer #(
        .SYNC_WIDTH(SW), .SYNC_PATTERN(PAT), .DATA_WIDTH(DW), .MSB_FIRST(1'b1)
    ) dut_msb (.clk(clk), .reset(reset), .bus(bus_m));

    serial_frame_deserializer #(
        .SYNC_WIDTH(SW), .SYNC_PATTERN(PAT), .DATA_WIDTH(DW), .MSB_FIRST(1'b0)
    ) dut_lsb (.clk(clk), .reset(reset), .bus(bus_l));

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            started = 1'b0;
    bit            m_locked, m_valid, m_ovf;
    bit            hq[$];
    bit            cq[$];
    logic [DW-1:0] m_word_m, m_word_l;
    logic [DW-1:0] expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit hist_matches();
        if (hq.size() != SW) return 1'b0;
        for (int i = 0; i < SW; i++)
            if (hq[i] != PAT[SW-1-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update(input bit r, input bit en, input bit sin, input bit rdy);
        bit            pop, done;
        logic [DW-1:0] wm, wl;
        started = 1'b1;
        if (r) begin
            m_locked = 0; m_valid = 0; m_ovf = 0;
            m_word_m = '0; m_word_l = '0;
            hq.delete(); cq.delete(); expq.delete();
            return;
        end
        pop   = m_valid && rdy;
        m_ovf = 0;
        done  = 0;
        wm = '0; wl = '0;
        if (en) begin
            if (!m_locked) begin
                hq.push_back(sin);
                if (hq.size() > SW) void'(hq.pop_front());
                if (hist_matches()) begin
                    m_locked = 1;
                    hq.delete();
                    cq.delete();
                end
            end else begin
                cq.push_back(sin);
                if (cq.size() == DW) begin
                    for (int i = 0; i < DW; i++) begin
                        wm[DW-1-i] = cq[i];
                        wl[i]      = cq[i];
                    end
                    done = 1;
                    m_locked = 0;
                    cq.delete();
                end
            end
        end
        if (done && (!m_valid || rdy)) begin
            m_valid = 1; m_word_m = wm; m_word_l = wl;
            expq.push_back(wm);
        end else begin
            if (done) m_ovf = 1;
            if (pop) m_valid = 0;
        end
    endtask

    // Monitor: per-cycle status checks plus scoreboard pop on each handshake
    always @(negedge clk) begin
        if (started) begin
            check("sync_locked_msb", bus_m.sync_locked, m_locked);
            check("sync_locked_lsb", bus_l.sync_locked, m_locked);
            check("data_valid_msb",  bus_m.data_valid,  m_valid);
            check("data_valid_lsb",  bus_l.data_valid,  m_valid);
            check("overflow_msb",    bus_m.overflow,    m_ovf);
            check("overflow_lsb",    bus_l.overflow,    m_ovf);
            check("data_out_msb",    bus_m.data_out,    m_word_m);
            check("data_out_lsb",    bus_l.data_out,    m_word_l);
            if (bus_m.data_valid === 1'b1 && bus_m.data_ready === 1'b1) begin
                if (expq.size() == 0) check("sb_unexpected_word", 1, 0);
                else                  check("sb_word", bus_m.data_out, expq.pop_front());
            end
        end
    end

    // rdy: 0/1 fixed, 2 random per cycle
    task automatic cyc(input bit r, input bit en, input bit sin, input int rdy);
        reset            = r;
        bus_m.bit_en     = en;
        bus_m.serial_in  = sin;
        bus_m.data_ready = (rdy == 2) ? bit'($urandom_range(0, 1)) : bit'(rdy);
        @(posedge clk);
        model_update(r, en, sin, bus_m.data_ready);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, input int rdy, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps) cyc(0, 0, bit'($urandom_range(0, 1)), rdy);
            cyc(0, 1, v[i], rdy);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input int rdy, input bit gaps);
        send_bits(32'(PAT), SW, rdy, gaps);
        send_bits(32'(w), DW, rdy, gaps);
    endtask

    task automatic idle(input int n, input int rdy);
        for (int i = 0; i < n; i++) cyc(0, 1, 1'b0, rdy);
    endtask

    initial begin
        reset = 1'b1; bus_m.bit_en = 1'b1; bus_m.serial_in = 1'b0; bus_m.data_ready = 1'b1;

        cyc(1, 1, bit'($urandom_range(0, 1)), 1);
        cyc(1, 1, bit'($urandom_range(0, 1)), 1);

        send_frame(8'hA5, 1, 0);
        idle(3, 1);

        send_bits(32'h78, SW, 1, 0);
        send_frame(8'h3C, 1, 0);
        idle(3, 1);

        send_frame(8'h11, 0, 0);
        send_frame(8'h22, 0, 0);
        idle(2, 0);
        idle(3, 1);

        send_bits(32'(PAT), SW, 1, 0);
        send_bits(32'hA, 4, 1, 0);
        cyc(1, 1, 1'b1, 1);
        send_frame(8'h5A, 1, 0);
        idle(3, 1);

        send_frame(8'hC3, 1, 1);
        idle(3, 1);

        for (int it = 0; it < 300; it++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 20)
                send_frame(DW'($urandom), 2, bit'($urandom_range(0, 1)));
            else if (sel < 22)
                cyc(1, 1, bit'($urandom_range(0, 1)), 2);
            else
                cyc(0, ($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 2);
        end

        for (int i = 0; i < 10; i++) cyc(0, 0, 1'b0, 1);
        check("sb_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
